// File: rtl/inst_fetch_ctrl_if.sv
// rtl/inst_fetch_ctrl_if.sv - fetch-side bus bundle: PC unit, icache lookup/refill, memory read port, decoder output
interface inst_fetch_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
);
    logic                  pc_valid;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pc_ack;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] cache_addr;
    logic                  cache_hit;
    logic [INST_WIDTH-1:0] cache_data;
    logic                  cache_update;
    logic [ADDR_WIDTH-1:0] cache_update_addr;
    logic [INST_WIDTH-1:0] cache_update_data;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_done;
    logic [INST_WIDTH-1:0] mem_data;
    logic                  inst_valid;
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic                  inst_ready;

    modport master (
        input  pc_valid, pc, flush, cache_hit, cache_data, mem_done, mem_data, inst_ready,
        output pc_ack, cache_addr, cache_update, cache_update_addr, cache_update_data,
        output mem_req, mem_addr, inst_valid, inst, inst_pc
    );

    modport slave (
        output pc_valid, pc, flush, cache_hit, cache_data, mem_done, mem_data, inst_ready,
        input  pc_ack, cache_addr, cache_update, cache_update_addr, cache_update_data,
        input  mem_req, mem_addr, inst_valid, inst, inst_pc
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - direct-mapped icache fetch sequencer with miss refill and flush drain
// Optional hit/miss statistics counters when ICACHE_STAT_EN is defined.
module inst_fetch_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    inst_fetch_ctrl_if.master  bus
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0]        stat_hit_cnt,
    output logic [31:0]        stat_miss_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MISS  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    logic   slot_free;
    logic   accept;

    assign slot_free = !bus.inst_valid || bus.inst_ready;
    assign accept    = (state == IDLE) && bus.pc_valid && slot_free && !bus.flush;

    // While a refill is outstanding the cache must keep looking at the miss address.
    assign bus.cache_addr = (state == IDLE) ? bus.pc : bus.mem_addr;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state                 <= IDLE;
            bus.pc_ack            <= 1'b0;
            bus.mem_req           <= 1'b0;
            bus.cache_update      <= 1'b0;
            bus.inst_valid        <= 1'b0;
            bus.inst              <= {INST_WIDTH{1'b0}};
            bus.inst_pc           <= {ADDR_WIDTH{1'b0}};
            bus.mem_addr          <= {ADDR_WIDTH{1'b0}};
            bus.cache_update_addr <= {ADDR_WIDTH{1'b0}};
            bus.cache_update_data <= {INST_WIDTH{1'b0}};
        end else if (rdy_in) begin
            bus.pc_ack       <= 1'b0;
            bus.cache_update <= 1'b0;
            if (bus.flush || bus.inst_ready) begin
                bus.inst_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.pc_ack <= 1'b1;
                        if (bus.cache_hit) begin
                            bus.inst_valid <= 1'b1;
                            bus.inst       <= bus.cache_data;
                            bus.inst_pc    <= bus.pc;
                        end else begin
                            bus.mem_addr <= bus.pc;
                            bus.mem_req  <= 1'b1;
                            state        <= MISS;
                        end
                    end
                end
                MISS: begin
                    if (bus.mem_done) begin
                        bus.mem_req           <= 1'b0;
                        bus.cache_update      <= 1'b1;
                        bus.cache_update_addr <= bus.mem_addr;
                        bus.cache_update_data <= bus.mem_data;
                        // A flush landing with the refill still fills the cache but drops the inst.
                        if (!bus.flush) begin
                            bus.inst_valid <= 1'b1;
                            bus.inst       <= bus.mem_data;
                            bus.inst_pc    <= bus.mem_addr;
                        end
                        state <= IDLE;
                    end else if (bus.flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.mem_done) begin
                        bus.mem_req           <= 1'b0;
                        bus.cache_update      <= 1'b1;
                        bus.cache_update_addr <= bus.mem_addr;
                        bus.cache_update_data <= bus.mem_data;
                        state                 <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_STAT_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stat_hit_cnt  <= 32'd0;
            stat_miss_cnt <= 32'd0;
        end else if (rdy_in) begin
            if (accept && bus.cache_hit) begin
                stat_hit_cnt <= stat_hit_cnt + 32'd1;
            end
            if (accept && !bus.cache_hit) begin
                stat_miss_cnt <= stat_miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - self-checking bench for inst_fetch_ctrl (table vectors plus scoreboard sequences)
module tb_inst_fetch_ctrl;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    inst_fetch_ctrl_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();

`ifdef ICACHE_STAT_EN
    logic [31:0] stat_hit_cnt;
    logic [31:0] stat_miss_cnt;
`endif

    inst_fetch_ctrl #(.ADDR_WIDTH(32), .INST_WIDTH(32)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
`ifdef ICACHE_STAT_EN
        ,
        .stat_hit_cnt  (stat_hit_cnt),
        .stat_miss_cnt (stat_miss_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    logic sb_on = 1'b0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } pair_t;

    pair_t inst_q[$];
    pair_t cu_q[$];

    typedef struct {
        logic        rst, pv;
        logic [31:0] pc;
        logic        fl, hit;
        logic [31:0] cdata;
        logic        md;
        logic [31:0] mdata;
        logic        ir;
        logic        e_ack, e_mreq;
        logic [31:0] e_maddr;
        logic        e_iv;
        logic [31:0] e_inst, e_ipc;
        logic        e_cupd;
        logic [31:0] e_cuaddr, e_cudata;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic rdy, input logic pv, input logic [31:0] pc,
                         input logic fl, input logic hit, input logic [31:0] cdata,
                         input logic md, input logic [31:0] mdata, input logic ir);
        rst_in         = rst;
        rdy_in         = rdy;
        bus.pc_valid   = pv;
        bus.pc         = pc;
        bus.flush      = fl;
        bus.cache_hit  = hit;
        bus.cache_data = cdata;
        bus.mem_done   = md;
        bus.mem_data   = mdata;
        bus.inst_ready = ir;
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    // Consumed instructions and completed cache writes are checked against queued expectations.
    always @(negedge clk_in) begin
        if (sb_on && rdy_in) begin
            if (bus.inst_valid && bus.inst_ready) begin
                if (inst_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_inst_unexpected actual_pc=%h required=none", bus.inst_pc);
                end else begin
                    pair_t e;
                    e = inst_q.pop_front();
                    chk("sb_inst_pc", bus.inst_pc, e.a);
                    chk("sb_inst", bus.inst, e.d);
                end
            end
            if (bus.cache_update) begin
                if (cu_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_cu_unexpected actual_addr=%h required=none", bus.cache_update_addr);
                end else begin
                    pair_t e;
                    e = cu_q.pop_front();
                    chk("sb_cu_addr", bus.cache_update_addr, e.a);
                    chk("sb_cu_data", bus.cache_update_data, e.d);
                end
            end
        end
    end

    initial begin
        //           rst pv pc     fl hit cdata         md mdata         ir  ack mreq maddr iv inst          ipc    cupd cuaddr cudata
        vecs[0]  = '{1, 0, 32'h0,  0, 0, 32'h0,        0, 32'h0,        0,  0, 0, 32'h0, 0, 32'h0,        32'h0,  0, 32'h0, 32'h0};
        vecs[1]  = '{0, 1, 32'h0,  0, 0, 32'h0,        0, 32'h0,        1,  1, 1, 32'h0, 0, 32'h0,        32'h0,  0, 32'h0, 32'h0};
        vecs[2]  = '{0, 0, 32'h0,  0, 0, 32'h0,        0, 32'h0,        1,  0, 1, 32'h0, 0, 32'h0,        32'h0,  0, 32'h0, 32'h0};
        vecs[3]  = vecs[2];
        vecs[4]  = vecs[2];
        vecs[5]  = vecs[2];
        vecs[6]  = '{0, 0, 32'h0,  0, 0, 32'h0,        1, 32'h513,      0,  0, 0, 32'h0, 1, 32'h513,      32'h0,  1, 32'h0, 32'h513};
        vecs[7]  = '{0, 1, 32'h4,  0, 1, 32'h00400093, 0, 32'h0,        1,  1, 0, 32'h0, 1, 32'h00400093, 32'h4,  0, 32'h0, 32'h513};
        vecs[8]  = '{0, 1, 32'h8,  0, 1, 32'h00800113, 0, 32'h0,        1,  1, 0, 32'h0, 1, 32'h00800113, 32'h8,  0, 32'h0, 32'h513};
        vecs[9]  = '{0, 1, 32'hC,  0, 1, 32'h00C00193, 0, 32'h0,        1,  1, 0, 32'h0, 1, 32'h00C00193, 32'hC,  0, 32'h0, 32'h513};
        vecs[10] = '{0, 0, 32'h0,  0, 0, 32'h0,        0, 32'h0,        1,  0, 0, 32'h0, 0, 32'h00C00193, 32'hC,  0, 32'h0, 32'h513};
        vecs[11] = '{0, 1, 32'h10, 0, 1, 32'h01000213, 0, 32'h0,        0,  1, 0, 32'h0, 1, 32'h01000213, 32'h10, 0, 32'h0, 32'h513};
        vecs[12] = '{0, 1, 32'h14, 1, 1, 32'h01400293, 0, 32'h0,        0,  0, 0, 32'h0, 0, 32'h01000213, 32'h10, 0, 32'h0, 32'h513};

        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst, 1'b1, vecs[i].pv, vecs[i].pc, vecs[i].fl, vecs[i].hit, vecs[i].cdata,
                  vecs[i].md, vecs[i].mdata, vecs[i].ir);
            cyc();
            chk($sformatf("v%0d_pc_ack", i), 32'(bus.pc_ack), 32'(vecs[i].e_ack));
            chk($sformatf("v%0d_mem_req", i), 32'(bus.mem_req), 32'(vecs[i].e_mreq));
            chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, vecs[i].e_maddr);
            chk($sformatf("v%0d_inst_valid", i), 32'(bus.inst_valid), 32'(vecs[i].e_iv));
            chk($sformatf("v%0d_inst", i), bus.inst, vecs[i].e_inst);
            chk($sformatf("v%0d_inst_pc", i), bus.inst_pc, vecs[i].e_ipc);
            chk($sformatf("v%0d_cache_update", i), 32'(bus.cache_update), 32'(vecs[i].e_cupd));
            chk($sformatf("v%0d_cu_addr", i), bus.cache_update_addr, vecs[i].e_cuaddr);
            chk($sformatf("v%0d_cu_data", i), bus.cache_update_data, vecs[i].e_cudata);
        end

        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc();
        sb_on = 1'b1;

        // Decoder stall: a held output blocks further accepts.
        inst_q.push_back('{32'h10, 32'hAAAA0010});
        drive(0, 1, 1, 32'h10, 0, 1, 32'hAAAA0010, 0, 0, 0);
        cyc();
        chk("stall_first_ack", 32'(bus.pc_ack), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 32'h14, 0, 1, 32'hAAAA0014, 0, 0, 0);
            cyc();
            chk("stall_no_ack", 32'(bus.pc_ack), 32'd0);
            chk("stall_inst_held", bus.inst, 32'hAAAA0010);
            chk("stall_valid_held", 32'(bus.inst_valid), 32'd1);
        end
        inst_q.push_back('{32'h14, 32'hAAAA0014});
        drive(0, 1, 1, 32'h14, 0, 1, 32'hAAAA0014, 0, 0, 1);
        cyc();
        chk("stall_release_ack", 32'(bus.pc_ack), 32'd1);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc();
        chk("stall_drained", 32'(bus.inst_valid), 32'd0);

        // Miss, flush two cycles later, drain until memory returns.
        drive(0, 1, 1, 32'h100, 0, 0, 0, 0, 0, 1);
        #1;
        chk("cache_addr_idle", bus.cache_addr, 32'h100);
        cyc();
        chk("drain_mem_req0", 32'(bus.mem_req), 32'd1);
        drive(0, 1, 0, 32'h999, 0, 0, 0, 0, 0, 1);
        #1;
        chk("cache_addr_miss", bus.cache_addr, 32'h100);
        cyc();
        drive(0, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        cyc();
        for (int i = 0; i < 2; i++) begin
            chk("drain_mem_req", 32'(bus.mem_req), 32'd1);
            chk("drain_no_inst", 32'(bus.inst_valid), 32'd0);
            drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
            cyc();
        end
        cu_q.push_back('{32'h100, 32'hDEADBEEF});
        drive(0, 1, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 1);
        cyc();
        chk("drain_cu", 32'(bus.cache_update), 32'd1);
        chk("drain_req_drop", 32'(bus.mem_req), 32'd0);
        chk("drain_no_inst_done", 32'(bus.inst_valid), 32'd0);
        inst_q.push_back('{32'h200, 32'h11110200});
        drive(0, 1, 1, 32'h200, 0, 1, 32'h11110200, 0, 0, 1);
        cyc();
        chk("post_drain_ack", 32'(bus.pc_ack), 32'd1);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc();

        // Global stall mid-miss with mem_done toggling; nothing may move.
        drive(0, 1, 1, 32'h300, 0, 0, 0, 0, 0, 1);
        cyc();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 32'h304, 0, 1, 32'h0, ((i % 2) == 0), 32'h12345678, 1);
            cyc();
            chk("frz_mem_req", 32'(bus.mem_req), 32'd1);
            chk("frz_mem_addr", bus.mem_addr, 32'h300);
            chk("frz_cu", 32'(bus.cache_update), 32'd0);
            chk("frz_iv", 32'(bus.inst_valid), 32'd0);
            chk("frz_ack", 32'(bus.pc_ack), 32'd0);
        end
        cu_q.push_back('{32'h300, 32'h33330300});
        inst_q.push_back('{32'h300, 32'h33330300});
        drive(0, 1, 0, 0, 0, 0, 0, 1, 32'h33330300, 1);
        cyc();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            cyc();
            chk("frz_pulse_held", 32'(bus.cache_update), 32'd1);
            chk("frz_inst_held", 32'(bus.inst_valid), 32'd1);
        end
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc();
        chk("frz_pulse_done", 32'(bus.cache_update), 32'd0);
        chk("frz_inst_done", 32'(bus.inst_valid), 32'd0);

        // Reset mid-miss, then a stray mem_done must be ignored.
        drive(0, 1, 1, 32'h400, 0, 0, 0, 0, 0, 1);
        cyc();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc();
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_inst", bus.inst, 32'd0);
        chk("rst_cu_data", bus.cache_update_data, 32'd0);
        drive(0, 1, 0, 0, 0, 0, 0, 1, 32'hBAD, 1);
        cyc();
        chk("stray_cu", 32'(bus.cache_update), 32'd0);
        chk("stray_iv", 32'(bus.inst_valid), 32'd0);
        inst_q.push_back('{32'h404, 32'h44440404});
        drive(0, 1, 1, 32'h404, 0, 1, 32'h44440404, 0, 0, 1);
        cyc();
        chk("post_rst_ack", 32'(bus.pc_ack), 32'd1);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc();

        // Flush coinciding with refill: cache written, inst dropped, back to IDLE.
        drive(0, 1, 1, 32'h500, 0, 0, 0, 0, 0, 1);
        cyc();
        cu_q.push_back('{32'h500, 32'h55550500});
        drive(0, 1, 0, 0, 1, 0, 0, 1, 32'h55550500, 1);
        cyc();
        chk("fldone_cu", 32'(bus.cache_update), 32'd1);
        chk("fldone_iv", 32'(bus.inst_valid), 32'd0);
        inst_q.push_back('{32'h504, 32'h55550504});
        drive(0, 1, 1, 32'h504, 0, 1, 32'h55550504, 0, 0, 1);
        cyc();
        chk("fldone_idle_ack", 32'(bus.pc_ack), 32'd1);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc();

`ifdef ICACHE_STAT_EN
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc();
        drive(0, 1, 1, 32'h700, 0, 0, 0, 0, 0, 1);
        cyc();
        cu_q.push_back('{32'h700, 32'h77770700});
        inst_q.push_back('{32'h700, 32'h77770700});
        drive(0, 1, 0, 0, 0, 0, 0, 1, 32'h77770700, 1);
        cyc();
        for (int i = 1; i <= 3; i++) begin
            inst_q.push_back('{32'h700 + 32'(4 * i), 32'h77770000 + 32'(i)});
            drive(0, 1, 1, 32'h700 + 32'(4 * i), 0, 1, 32'h77770000 + 32'(i), 0, 0, 1);
            cyc();
        end
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc();
        chk("stat_miss", stat_miss_cnt, 32'd1);
        chk("stat_hit", stat_hit_cnt, 32'd3);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc();
        chk("stat_miss_rst", stat_miss_cnt, 32'd0);
        chk("stat_hit_rst", stat_hit_cnt, 32'd0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc();
`endif

        cyc();
        chk("inst_q_empty", 32'(inst_q.size()), 32'd0);
        chk("cu_q_empty", 32'(cu_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Sequences the direct-mapped instruction cache for the fetch stage.
- Accepts a PC from the fetch/PC unit and looks it up in the cache. On a hit it returns the instruction.
- On a miss it requests a 32-bit word from the memory controller, writes the word into the cache, then returns the instruction.
- Sits between the PC unit, the instruction cache and the memory controller read port. Handles flush on branch misprediction.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory addresses.
- INST_WIDTH, 32, width of instruction / cache data word.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; all registers hold when low
- pc_valid  input  1  PC unit offers a fetch address
- pc  input  ADDR_WIDTH  fetch address
- pc_ack  output  1  1-cycle pulse when pc is accepted
- flush  input  1  discard in-flight fetch and pending output
- cache_addr  output  ADDR_WIDTH  lookup address to cache (combinational)
- cache_hit  input  1  cache hit for cache_addr
- cache_data  input  INST_WIDTH  cache data for cache_addr
- cache_update  output  1  cache write strobe (1 cycle)
- cache_update_addr  output  ADDR_WIDTH  cache write address
- cache_update_data  output  INST_WIDTH  cache write data
- mem_req  output  1  memory read request, level
- mem_addr  output  ADDR_WIDTH  memory read address
- mem_done  input  1  1-cycle pulse: mem_data valid
- mem_data  input  INST_WIDTH  fetched word
- inst_valid  output  1  instruction available to decoder
- inst  output  INST_WIDTH  instruction
- inst_pc  output  ADDR_WIDTH  PC of inst
- inst_ready  input  1  decoder consumes inst this cycle

Behaviour:
- Clock is clk_in; reset is rst_in, synchronous, active-high. Every register changes only at posedge clk_in, and only when rdy_in=1 (rst_in has priority over rdy_in).
- Reset values:
  - State=IDLE.
  - pc_ack, mem_req, cache_update, inst_valid = 0.
  - inst, inst_pc, mem_addr, cache_update_addr, cache_update_data = 0.
- Output slot is free when inst_valid=0, or when inst_valid=1 and inst_ready=1 in the same cycle.
- cache_addr = pc in IDLE; otherwise it is the latched miss address.
- States:
  - IDLE: if pc_valid and slot free and !flush, assert pc_ack (registered, next cycle) and latch pc.
    - If cache_hit, set inst_valid=1, inst=cache_data and inst_pc=pc at the next edge (hit latency 1 cycle). Stay in IDLE; back-to-back hits give one instruction per cycle.
    - If !cache_hit, set mem_addr=pc and mem_req=1, and go to MISS.
  - MISS: hold mem_req=1 and mem_addr stable until mem_done. On mem_done:
    - mem_req=0.
    - cache_update=1 for exactly one cycle, with cache_update_addr=mem_addr and cache_update_data=mem_data.
    - inst_valid=1, inst=mem_data, inst_pc=mem_addr.
    - Go to IDLE. The refill-to-inst latency is 1 cycle after mem_done.
  - DRAIN: entered from MISS when flush. mem_req stays 1 until mem_done, because the memory controller cannot abort. On mem_done:
    - The cache is still updated (the data is correct for the address).
    - No instruction is produced.
    - Go to IDLE.
- Miss entry only happens when the slot is free, so inst_valid is 0 or consumed before refill completes. No overwrite of an unconsumed inst is possible.
- inst_valid clears when inst_ready=1 and no new instruction loads in the same cycle.
- flush, any state:
  - Clears inst_valid next edge. No pc accept that cycle.
  - MISS goes to DRAIN. IDLE stays IDLE.
- flush together with mem_done in MISS: update the cache, drop the instruction, go to IDLE.
- flush in DRAIN: no effect beyond clearing inst_valid.
- Reset mid-MISS/DRAIN: all state clears immediately. A later stray mem_done in IDLE is ignored.
- rdy_in=0: all outputs are held, including a pending cache_update pulse. The pulse completes on the first rdy_in=1 cycle.

Optional Feature:
- ICACHE_STAT_EN defined: adds outputs stat_hit_cnt[31:0] and stat_miss_cnt[31:0], reset to 0.
  - Hit counter increments on each accepted hit.
  - Miss counter increments on each IDLE→MISS transition.
  - Counters wrap at 2^32 and are frozen when rdy_in=0.
- ICACHE_STAT_EN undefined: the ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then pc_valid=1, pc=0x0000_0000, cache_hit=0; mem_done after 5 cycles with mem_data=0x0000_0513 → mem_req high 5 cycles, mem_addr=0x0; cache_update 1 cycle with addr 0x0 and data 0x0000_0513; inst_valid=1, inst=0x0000_0513, inst_pc=0x0.
- Hits at pc=0x4, 0x8, 0xC with inst_ready=1 → three pc_ack and inst_valid on 3 consecutive cycles, inst_pc=0x4, 0x8, 0xC; mem_req stays 0.
- Hit with inst_ready=0 for 3 cycles while pc_valid=1 → inst held stable, no pc_ack until inst_ready=1.
- Miss at 0x100, flush 2 cycles later, mem_done with 0xDEAD_BEEF → mem_req held until mem_done; cache_update fires with addr 0x100; inst_valid never asserts; next pc accepted in IDLE.
- rdy_in=0 for 4 cycles mid-MISS with mem_done pulsing → all outputs frozen; after rdy_in=1 the refill completes normally.
- ICACHE_STAT_EN: 1 miss and 3 hits → stat_miss_cnt=1, stat_hit_cnt=3; rst_in=1 → both 0.
